// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges execute to the memory arbiter's LSU ports. Takes one load or
//   store at a time. Stores go out as a single word-aligned write with byte
//   enables and lane-replicated data. Loads go out as word reads; the
//   addressed lane is extracted, sign/zero-extended and returned with a
//   one-cycle response pulse. Misaligned or illegal-size requests complete
//   immediately with o_misaligned set and make no bus access.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_clk_en                global enable; everything freezes while low
//   i_stall                 arbiter stall; holds FSM/outputs (load ack excepted)
//   i_req_*                 request from execute (valid/we/size/unsigned/addr/wdata)
//   o_req_ready             idle, can accept a request (decoded from state)
//   o_resp_valid/_data      completion pulse and extended load data (0 for stores)
//   o_misaligned            qualifies o_resp_valid
//   o_lsu_read, o_r_lsu_addr, i_r_lsu_data, i_lsu_ack   arbiter read channel
//   o_lsu_write, o_w_lsu_addr, o_w_lsu_byte_en, o_w_lsu_data   arbiter write channel
module load_store_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  input  logic          i_stall,
  input  logic          i_req_valid,
  input  logic          i_req_we,
  input  logic [1:0]    i_req_size,
  input  logic          i_req_unsigned,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_req_ready,
  output logic          o_resp_valid,
  output logic [DW-1:0] o_resp_data,
  output logic          o_misaligned,
  output logic          o_lsu_read,
  output logic [AW-1:0] o_r_lsu_addr,
  input  logic [DW-1:0] i_r_lsu_data,
  input  logic          i_lsu_ack,
  output logic          o_lsu_write,
  output logic [AW-1:0] o_w_lsu_addr,
  output logic [3:0]    o_w_lsu_byte_en,
  output logic [DW-1:0] o_w_lsu_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e state_q, state_d;

  // Only the parts of the request needed after acceptance are kept: the
  // lane/size/extension control for load data extraction.
  logic [1:0] lane_q,     lane_d;
  logic [1:0] size_q,     size_d;
  logic       unsigned_q, unsigned_d;

  // Next values of the registered outputs.
  logic          resp_valid_d;
  logic [DW-1:0] resp_data_d;
  logic          misaligned_d;
  logic          lsu_read_d;
  logic [AW-1:0] r_lsu_addr_d;
  logic          lsu_write_d;
  logic [AW-1:0] w_lsu_addr_d;
  logic [3:0]    w_lsu_byte_en_d;
  logic [DW-1:0] w_lsu_data_d;

  logic          accept;
  logic          req_misaligned;
  logic [AW-1:0] req_word_addr;
  logic [DW-1:0] rd_shifted;
  logic [DW-1:0] rd_extended;

  assign accept        = i_req_valid && !i_stall;
  assign req_word_addr = {i_req_addr[AW-1:2], 2'b00};
  assign o_req_ready   = (state_q == S_IDLE);

  always_comb begin
    unique case (i_req_size)
      SZ_BYTE: req_misaligned = 1'b0;
      SZ_HALF: req_misaligned = i_req_addr[0];
      SZ_WORD: req_misaligned = (i_req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b1;
    endcase
  end

  // Lane extraction: shift the addressed lane down to bit 0, then extend.
  assign rd_shifted = i_r_lsu_data >> {lane_q, 3'b000};

  always_comb begin
    unique case (size_q)
      SZ_BYTE: rd_extended = {{(DW-8){rd_shifted[7] & ~unsigned_q}},   rd_shifted[7:0]};
      SZ_HALF: rd_extended = {{(DW-16){rd_shifted[15] & ~unsigned_q}}, rd_shifted[15:0]};
      default: rd_extended = i_r_lsu_data;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst)         state_q <= S_IDLE;
    else if (i_clk_en) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_misaligned) state_d = S_RESP;
          else if (i_req_we)  state_d = S_WRITE;
          else                state_d = S_READ;
        end
      end
      S_WRITE: if (!i_stall)  state_d = S_RESP;
      // The read ack is honoured even while stalled.
      S_READ:  if (i_lsu_ack) state_d = S_RESP;
      S_RESP:  if (!i_stall)  state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, holding by default.
  always_comb begin
    lane_d          = lane_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    resp_valid_d    = o_resp_valid;
    resp_data_d     = o_resp_data;
    misaligned_d    = o_misaligned;
    lsu_read_d      = o_lsu_read;
    r_lsu_addr_d    = o_r_lsu_addr;
    lsu_write_d     = o_lsu_write;
    w_lsu_addr_d    = o_w_lsu_addr;
    w_lsu_byte_en_d = o_w_lsu_byte_en;
    w_lsu_data_d    = o_w_lsu_data;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          lane_d       = i_req_addr[1:0];
          size_d       = i_req_size;
          unsigned_d   = i_req_unsigned;
          misaligned_d = req_misaligned;
          resp_data_d  = '0;
          if (req_misaligned) begin
            resp_valid_d = 1'b1;
          end else if (i_req_we) begin
            lsu_write_d  = 1'b1;
            w_lsu_addr_d = req_word_addr;
            unique case (i_req_size)
              SZ_BYTE: begin
                w_lsu_byte_en_d = 4'b0001 << i_req_addr[1:0];
                w_lsu_data_d    = {4{i_req_wdata[7:0]}};
              end
              SZ_HALF: begin
                w_lsu_byte_en_d = 4'b0011 << i_req_addr[1:0];
                w_lsu_data_d    = {2{i_req_wdata[15:0]}};
              end
              default: begin
                w_lsu_byte_en_d = 4'b1111;
                w_lsu_data_d    = i_req_wdata;
              end
            endcase
          end else begin
            lsu_read_d   = 1'b1;
            r_lsu_addr_d = req_word_addr;
          end
        end
      end
      S_WRITE: begin
        if (!i_stall) begin
          lsu_write_d  = 1'b0;
          resp_valid_d = 1'b1;
        end
      end
      S_READ: begin
        if (i_lsu_ack) begin
          lsu_read_d   = 1'b0;
          resp_data_d  = rd_extended;
          resp_valid_d = 1'b1;
        end
      end
      S_RESP: begin
        if (!i_stall) resp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output and request-context registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lane_q          <= '0;
      size_q          <= '0;
      unsigned_q      <= 1'b0;
      o_resp_valid    <= 1'b0;
      o_resp_data     <= '0;
      o_misaligned    <= 1'b0;
      o_lsu_read      <= 1'b0;
      o_r_lsu_addr    <= '0;
      o_lsu_write     <= 1'b0;
      o_w_lsu_addr    <= '0;
      o_w_lsu_byte_en <= '0;
      o_w_lsu_data    <= '0;
    end else if (i_clk_en) begin
      lane_q          <= lane_d;
      size_q          <= size_d;
      unsigned_q      <= unsigned_d;
      o_resp_valid    <= resp_valid_d;
      o_resp_data     <= resp_data_d;
      o_misaligned    <= misaligned_d;
      o_lsu_read      <= lsu_read_d;
      o_r_lsu_addr    <= r_lsu_addr_d;
      o_lsu_write     <= lsu_write_d;
      o_w_lsu_addr    <= w_lsu_addr_d;
      o_w_lsu_byte_en <= w_lsu_byte_en_d;
      o_w_lsu_data    <= w_lsu_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_clk_en;
  logic        i_stall;
  logic        i_req_valid;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_req_ready;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;
  logic        o_misaligned;
  logic        o_lsu_read;
  logic [31:0] o_r_lsu_addr;
  logic [31:0] i_r_lsu_data;
  logic        i_lsu_ack;
  logic        o_lsu_write;
  logic [31:0] o_w_lsu_addr;
  logic [3:0]  o_w_lsu_byte_en;
  logic [31:0] o_w_lsu_data;

  int passed = 0;
  int total  = 0;

  load_store_unit #(.AW(32), .DW(32)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_clk_en        (i_clk_en),
    .i_stall         (i_stall),
    .i_req_valid     (i_req_valid),
    .i_req_we        (i_req_we),
    .i_req_size      (i_req_size),
    .i_req_unsigned  (i_req_unsigned),
    .i_req_addr      (i_req_addr),
    .i_req_wdata     (i_req_wdata),
    .o_req_ready     (o_req_ready),
    .o_resp_valid    (o_resp_valid),
    .o_resp_data     (o_resp_data),
    .o_misaligned    (o_misaligned),
    .o_lsu_read      (o_lsu_read),
    .o_r_lsu_addr    (o_r_lsu_addr),
    .i_r_lsu_data    (i_r_lsu_data),
    .i_lsu_ack       (i_lsu_ack),
    .o_lsu_write     (o_lsu_write),
    .o_w_lsu_addr    (o_w_lsu_addr),
    .o_w_lsu_byte_en (o_w_lsu_byte_en),
    .o_w_lsu_data    (o_w_lsu_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a request for one edge; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_addr     = addr;
    i_req_wdata    = wdata;
    tick();
    i_req_valid    = 1'b0;
  endtask

  // Load with the ack arriving two cycles after the read is first visible.
  task automatic load_late_ack(input string tag, input logic uns, input logic [31:0] addr,
                               input logic [31:0] word, input logic [31:0] exp);
    check({tag, "_ready"}, o_req_ready, 1);
    issue(1'b0, 2'd0, uns, addr, 32'h0);
    check({tag, "_read0"}, o_lsu_read, 1);
    check({tag, "_raddr"}, o_r_lsu_addr, {addr[31:2], 2'b00});
    tick();
    check({tag, "_read1"}, o_lsu_read, 1);
    tick();
    check({tag, "_read2"}, o_lsu_read, 1);
    i_lsu_ack    = 1'b1;
    i_r_lsu_data = word;
    tick();
    i_lsu_ack    = 1'b0;
    i_r_lsu_data = 32'h0;
    check({tag, "_read_drop"}, o_lsu_read, 0);
    check({tag, "_resp"}, o_resp_valid, 1);
    check({tag, "_mis"}, o_misaligned, 0);
    check({tag, "_data"}, o_resp_data, exp);
    tick();
    check({tag, "_resp_end"}, o_resp_valid, 0);
    check({tag, "_data_hold"}, o_resp_data, exp);
  endtask

  task automatic misaligned_req(input string tag, input logic [1:0] size, input logic [31:0] addr);
    check({tag, "_ready"}, o_req_ready, 1);
    issue(1'b0, size, 1'b0, addr, 32'h0);
    check({tag, "_resp"}, o_resp_valid, 1);
    check({tag, "_mis"}, o_misaligned, 1);
    check({tag, "_no_read"}, o_lsu_read, 0);
    check({tag, "_no_write"}, o_lsu_write, 0);
    check({tag, "_data"}, o_resp_data, 0);
    tick();
    check({tag, "_resp_end"}, o_resp_valid, 0);
    check({tag, "_no_read2"}, o_lsu_read, 0);
    check({tag, "_mis_hold"}, o_misaligned, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst          = 1'b1;
    i_clk_en       = 1'b1;
    i_stall        = 1'b0;
    i_req_valid    = 1'b0;
    i_req_we       = 1'b0;
    i_req_size     = 2'd0;
    i_req_unsigned = 1'b0;
    i_req_addr     = 32'h0;
    i_req_wdata    = 32'h0;
    i_r_lsu_data   = 32'h0;
    i_lsu_ack      = 1'b0;
    tick();
    tick();
    check("rst_ready", o_req_ready, 1);
    check("rst_resp", o_resp_valid, 0);
    check("rst_read", o_lsu_read, 0);
    check("rst_write", o_lsu_write, 0);
    check("rst_data", o_resp_data, 0);
    check("rst_mis", o_misaligned, 0);
    check("rst_be", o_w_lsu_byte_en, 0);
    i_rst = 1'b0;
    tick();

    // SW 0x104
    check("sw_ready", o_req_ready, 1);
    issue(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF);
    check("sw_write", o_lsu_write, 1);
    check("sw_addr", o_w_lsu_addr, 32'h104);
    check("sw_be", o_w_lsu_byte_en, 4'hF);
    check("sw_data", o_w_lsu_data, 32'hDEADBEEF);
    check("sw_busy", o_req_ready, 0);
    check("sw_no_resp", o_resp_valid, 0);
    tick();
    check("sw_write_end", o_lsu_write, 0);
    check("sw_resp", o_resp_valid, 1);
    check("sw_mis", o_misaligned, 0);
    check("sw_rdata", o_resp_data, 0);
    tick();
    check("sw_resp_end", o_resp_valid, 0);
    check("sw_idle", o_req_ready, 1);

    // SB 0x203
    issue(1'b1, 2'd0, 1'b0, 32'h203, 32'h000000A5);
    check("sb_write", o_lsu_write, 1);
    check("sb_addr", o_w_lsu_addr, 32'h200);
    check("sb_be", o_w_lsu_byte_en, 4'b1000);
    check("sb_data", o_w_lsu_data, 32'hA5A5A5A5);
    tick();
    check("sb_resp", o_resp_valid, 1);
    tick();

    // LB / LBU at 0x302, lane 2 of 0x12F03456 is 0xF0
    load_late_ack("lb",  1'b0, 32'h302, 32'h12F03456, 32'hFFFFFFF0);
    load_late_ack("lbu", 1'b1, 32'h302, 32'h12F03456, 32'h000000F0);

    // Misaligned half and illegal size
    misaligned_req("lh_mis", 2'd1, 32'h401);
    misaligned_req("sz3", 2'd3, 32'h400);

    // SH 0x502 with three stalled cycles in WRITE
    issue(1'b1, 2'd1, 1'b0, 32'h502, 32'h0000BEEF);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sh_write_%0d", k), o_lsu_write, 1);
      check($sformatf("sh_be_%0d", k), o_w_lsu_byte_en, 4'b1100);
      check($sformatf("sh_data_%0d", k), o_w_lsu_data, 32'hBEEFBEEF);
      check($sformatf("sh_addr_%0d", k), o_w_lsu_addr, 32'h500);
      check($sformatf("sh_no_resp_%0d", k), o_resp_valid, 0);
      i_stall = (k < 3);
      tick();
    end
    i_stall = 1'b0;
    check("sh_write_end", o_lsu_write, 0);
    check("sh_resp", o_resp_valid, 1);
    tick();
    check("sh_resp_once", o_resp_valid, 0);
    tick();
    check("sh_resp_once2", o_resp_valid, 0);

    // Clock enable low stretches the response pulse
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h01234567);
    tick();
    check("ce_resp", o_resp_valid, 1);
    i_clk_en = 1'b0;
    tick();
    check("ce_hold1", o_resp_valid, 1);
    tick();
    check("ce_hold2", o_resp_valid, 1);
    i_clk_en = 1'b1;
    tick();
    check("ce_resp_end", o_resp_valid, 0);
    check("ce_idle", o_req_ready, 1);

    // Reset mid-READ, then a late ack must be ignored
    issue(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
    check("rr_read", o_lsu_read, 1);
    tick();
    i_rst = 1'b1;
    #1;
    check("rr_read_drop", o_lsu_read, 0);
    check("rr_ready", o_req_ready, 1);
    tick();
    i_rst = 1'b0;
    i_lsu_ack    = 1'b1;
    i_r_lsu_data = 32'hCAFEF00D;
    tick();
    i_lsu_ack    = 1'b0;
    check("rr_no_resp", o_resp_valid, 0);
    check("rr_ready2", o_req_ready, 1);
    tick();
    check("rr_no_resp2", o_resp_valid, 0);
    check("rr_data", o_resp_data, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
